// File: rtl/fpga_pkg.sv
// Shared AXI encodings and the fromhost initiator state type.
package fpga_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_B,
    RD_A,
    RD_R,
    RSP
  } fromhost_state_e;

endpackage

// File: rtl/axi_fromhost_master.sv
// Single-outstanding AXI4 initiator: turns one 64-bit host request into a
// single-beat AXI write or read on a DATA_W-wide bus and reports completion.
module axi_fromhost_master
  import fpga_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [63:0]         req_data_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [63:0]         rsp_data_o,
  output logic                rsp_err_o,
  output logic                aw_valid_o,
  input  logic                aw_ready_i,
  output logic [ADDR_W-1:0]   aw_addr_o,
  output logic [ID_W-1:0]     aw_id_o,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [DATA_W-1:0]   w_data_o,
  output logic [DATA_W/8-1:0] w_strb_o,
  output logic                w_last_o,
  input  logic                b_valid_i,
  output logic                b_ready_o,
  input  logic [1:0]          b_resp_i,
  input  logic [ID_W-1:0]     b_id_i,
  output logic                ar_valid_o,
  input  logic                ar_ready_i,
  output logic [ADDR_W-1:0]   ar_addr_o,
  output logic [ID_W-1:0]     ar_id_o,
  input  logic                r_valid_i,
  output logic                r_ready_o,
  input  logic [DATA_W-1:0]   r_data_i,
  input  logic [1:0]          r_resp_i,
  input  logic [ID_W-1:0]     r_id_i,
  input  logic                r_last_i,
  output logic [7:0]          ax_len_o,
  output logic [2:0]          ax_size_o,
  output logic [1:0]          ax_burst_o
);

  localparam int LANES  = DATA_W / 64;
  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  // 64-bit lane within the bus word addressed by a byte address.
  function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] idx;
    idx = (a >> 3) & ADDR_W'(LANES - 1);
    return idx[LANE_W-1:0];
  endfunction

  function automatic logic [STRB_W-1:0] strb_of(input logic [LANE_W-1:0] l);
    return STRB_W'(8'hFF) << ({l, 3'b000});
  endfunction

  fromhost_state_e    state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  strb_q, strb_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               init_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      lane_q     <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      lane_q     <= lane_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      init_q     <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    lane_d     = lane_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d     = req_addr_i;
          wdata_d    = {LANES{req_data_i}};
          lane_d     = lane_of(req_addr_i);
          strb_d     = strb_of(lane_of(req_addr_i));
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          // Misaligned requests never reach the bus.
          if (req_addr_i[2:0] != 3'b000) begin
            rsp_err_d = 1'b1;
            state_d   = RSP;
          end else begin
            state_d = req_we_i ? WR : RD_A;
          end
        end
      end
      WR: begin
        aw_done_d = aw_done_q | aw_ready_i;
        w_done_d  = w_done_q | w_ready_i;
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (b_valid_i) begin
          rsp_err_d  = (axi_resp_e'(b_resp_i) != OKAY) | (b_id_i != ID_W'(AXI_ID));
          rsp_data_d = '0;
          state_d    = RSP;
        end
      end
      RD_A: begin
        if (ar_ready_i) state_d = RD_R;
      end
      RD_R: begin
        if (r_valid_i) begin
          rsp_data_d = r_data_i[{lane_q, 6'b000000} +: 64];
          rsp_err_d  = (axi_resp_e'(r_resp_i) != OKAY) | (r_id_i != ID_W'(AXI_ID)) | ~r_last_i;
          state_d    = RSP;
        end
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o = init_q && (state_q == IDLE);
  assign aw_valid_o  = (state_q == WR) && !aw_done_q;
  assign w_valid_o   = (state_q == WR) && !w_done_q;
  assign w_last_o    = w_valid_o;
  assign b_ready_o   = (state_q == WR_B);
  assign ar_valid_o  = (state_q == RD_A);
  assign r_ready_o   = (state_q == RD_R);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign aw_addr_o   = addr_q;
  assign ar_addr_o   = addr_q;
  assign aw_id_o     = ID_W'(AXI_ID);
  assign ar_id_o     = ID_W'(AXI_ID);
  assign w_data_o    = wdata_q;
  assign w_strb_o    = strb_q;
  assign ax_len_o    = 8'd0;
  assign ax_size_o   = AXI_SIZE_8B;
  assign ax_burst_o  = AXI_BURST_INCR;

endmodule

// File: tb/tb_axi_fromhost_master.sv
// Directed bench for axi_fromhost_master: vector table plus corner-case sequences.
module tb_axi_fromhost_master;

  logic         clk = 1'b0;
  logic         rstn_i = 1'b0;
  logic         req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
  logic [63:0]  req_addr_i = '0, req_data_i = '0;
  logic         rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
  logic [63:0]  rsp_data_o;
  logic         aw_valid_o, aw_ready_i = 1'b1;
  logic [63:0]  aw_addr_o, ar_addr_o;
  logic [3:0]   aw_id_o, ar_id_o, b_id_i = '0, r_id_i = '0;
  logic         w_valid_o, w_ready_i = 1'b1, w_last_o;
  logic [511:0] w_data_o, r_data_i = '0;
  logic [63:0]  w_strb_o;
  logic         b_valid_i = 1'b1, b_ready_o;
  logic [1:0]   b_resp_i = '0, r_resp_i = '0;
  logic         ar_valid_o, ar_ready_i = 1'b1;
  logic         r_valid_i = 1'b1, r_ready_o, r_last_i = 1'b1;
  logic [7:0]   ax_len_o;
  logic [2:0]   ax_size_o;
  logic [1:0]   ax_burst_o;

  axi_fromhost_master dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i), .b_id_i(b_id_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o), .ar_id_o(ar_id_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .r_id_i(r_id_i), .r_last_i(r_last_i),
    .ax_len_o(ax_len_o), .ax_size_o(ax_size_o), .ax_burst_o(ax_burst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
    logic [63:0] exp_data;
    logic        exp_err;
    logic [63:0] exp_strb;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];
  int tests = 0;
  int fails = 0;

  // Observations gathered while waiting for a response.
  logic         saw_aw, saw_w, saw_ar, saw_bready, bready_early;
  logic [63:0]  aw_addr_seen, ar_addr_seen, strb_seen;
  logic [511:0] wdata_seen;
  int           aw_cnt, w_cnt, lat;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] data);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_we_i = we; req_addr_i = addr; req_data_i = data; req_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready_o) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1 req_valid_i = 1'b0;
    chk("req_accepted", 512'(ok), 512'd1);
  endtask

  task automatic wait_rsp(input int aw_delay);
    saw_aw = 0; saw_w = 0; saw_ar = 0; saw_bready = 0; bready_early = 0;
    aw_addr_seen = '0; ar_addr_seen = '0; strb_seen = '0; wdata_seen = '0;
    aw_cnt = 0; w_cnt = 0; lat = 0;
    if (aw_delay > 0) aw_ready_i = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (aw_valid_o) begin
        saw_aw = 1; aw_addr_seen = aw_addr_o; aw_cnt++;
        if (aw_delay > 0 && aw_cnt == aw_delay) aw_ready_i = 1'b1;
      end
      if (w_valid_o) begin
        saw_w = 1; w_cnt++; strb_seen = w_strb_o; wdata_seen = w_data_o;
      end
      if (ar_valid_o) begin
        saw_ar = 1; ar_addr_seen = ar_addr_o;
      end
      if (b_ready_o) begin
        saw_bready = 1;
        if (aw_valid_o || w_valid_o) bready_early = 1;
      end
      if (rsp_valid_o) begin
        lat = n;
        break;
      end
    end
    aw_ready_i = 1'b1;
  endtask

  task automatic finish_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("rsp_valid_after_hs", 512'(rsp_valid_o), 512'd0);
    chk("req_ready_after_hs", 512'(req_ready_o), 512'd1);
  endtask

  task automatic set_rdata(input logic [63:0] addr, input logic [63:0] val);
    for (int k = 0; k < 8; k++) r_data_i[k*64 +: 64] = 64'hBAD0_0000_0000_0000 | 64'(k);
    r_data_i[((addr >> 3) & 64'd7)*64 +: 64] = val;
  endtask

  initial begin
    logic [511:0] rep;
    int rcnt;

    //            we    addr                    data                    resp  id     last  exp_data     err   exp_strb                 lat
    vecs[0] = '{1'b1, 64'h0000_0000_8000_1008, 64'hDEAD_BEEF_0000_0001, 2'd0, 4'd0, 1'b1, 64'h0,       1'b0, 64'h0000_0000_0000_FF00, 3};
    vecs[1] = '{1'b0, 64'h38,                  64'h1234,               2'd0, 4'd0, 1'b1, 64'h1234,    1'b0, 64'h0,                   3};
    vecs[2] = '{1'b1, 64'h40,                  64'h0123_4567_89AB_CDEF, 2'd2, 4'd0, 1'b1, 64'h0,       1'b1, 64'h0000_0000_0000_00FF, 3};
    vecs[3] = '{1'b0, 64'h10,                  64'h5555,               2'd0, 4'd5, 1'b1, 64'h5555,    1'b1, 64'h0,                   3};
    vecs[4] = '{1'b0, 64'h28,                  64'hCAFE,               2'd0, 4'd0, 1'b0, 64'hCAFE,    1'b1, 64'h0,                   3};
    vecs[5] = '{1'b0, 64'h0,                   64'h77,                 2'd3, 4'd0, 1'b1, 64'h77,      1'b1, 64'h0,                   3};
    vecs[6] = '{1'b1, 64'h30,                  64'hFEED,               2'd0, 4'd3, 1'b1, 64'h0,       1'b1, 64'h00FF_0000_0000_0000, 3};
    vecs[7] = '{1'b0, 64'h4,                   64'h99,                 2'd0, 4'd0, 1'b1, 64'h0,       1'b1, 64'h0,                   1};
    vecs[8] = '{1'b1, 64'h18,                  64'h4242,               2'd1, 4'd0, 1'b1, 64'h0,       1'b1, 64'h0000_0000_FF00_0000, 3};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valids", 512'({aw_valid_o, w_valid_o, ar_valid_o, rsp_valid_o, b_ready_o, r_ready_o}), 512'd0);
    chk("rst_fields", 512'({aw_addr_o, w_strb_o, rsp_data_o, 1'(rsp_err_o)}), 512'd0);
    chk("rst_wdata", w_data_o, 512'd0);
    rstn_i = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 512'(req_ready_o), 512'd1);
    chk("ax_consts", 512'({ax_len_o, ax_size_o, ax_burst_o}), 512'({8'd0, 3'd3, 2'd1}));

    for (int v = 0; v < 9; v++) begin
      b_resp_i = vecs[v].resp; b_id_i = vecs[v].id;
      r_resp_i = vecs[v].resp; r_id_i = vecs[v].id; r_last_i = vecs[v].last;
      b_valid_i = 1'b1; r_valid_i = 1'b1;
      set_rdata(vecs[v].addr, vecs[v].data);
      issue(vecs[v].we, vecs[v].addr, vecs[v].data);
      wait_rsp(0);
      chk($sformatf("v%0d_latency", v), 512'(lat), 512'(vecs[v].exp_lat));
      chk($sformatf("v%0d_rsp_data", v), 512'(rsp_data_o), 512'(vecs[v].exp_data));
      chk($sformatf("v%0d_rsp_err", v), 512'(rsp_err_o), 512'(vecs[v].exp_err));
      if (vecs[v].addr[2:0] != 3'b000) begin
        chk($sformatf("v%0d_no_axi", v), 512'({saw_aw, saw_w, saw_ar, saw_bready}), 512'd0);
      end else if (vecs[v].we) begin
        rep = {8{vecs[v].data}};
        chk($sformatf("v%0d_aw_addr", v), 512'(aw_addr_seen), 512'(vecs[v].addr));
        chk($sformatf("v%0d_w_strb", v), 512'(strb_seen), 512'(vecs[v].exp_strb));
        chk($sformatf("v%0d_w_data", v), wdata_seen, rep);
        chk($sformatf("v%0d_bready", v), 512'({saw_bready, saw_ar}), 512'({1'b1, 1'b0}));
      end else begin
        chk($sformatf("v%0d_ar_addr", v), 512'(ar_addr_seen), 512'(vecs[v].addr));
        chk($sformatf("v%0d_rd_only", v), 512'({saw_bready, saw_aw, saw_w}), 512'd0);
      end
      $display("[TB] txn %0d we=%0b addr=%h data=%h err=%0b lat=%0d",
               v, vecs[v].we, vecs[v].addr, rsp_data_o, rsp_err_o, lat);
      finish_rsp();
    end

    // AW ready late, W ready immediately
    b_resp_i = 2'd0; b_id_i = 4'd0; b_valid_i = 1'b1;
    issue(1'b1, 64'h100, 64'h1111_2222_3333_4444);
    wait_rsp(5);
    chk("awdly_aw_cycles", 512'(aw_cnt), 512'd5);
    chk("awdly_w_cycles", 512'(w_cnt), 512'd1);
    chk("awdly_bready_early", 512'(bready_early), 512'd0);
    chk("awdly_latency", 512'(lat), 512'd7);
    chk("awdly_err", 512'(rsp_err_o), 512'd0);
    $display("[TB] txn awdly addr=%h err=%0b lat=%0d", 64'h100, rsp_err_o, lat);
    finish_rsp();
    rcnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid_o) rcnt++;
    end
    chk("awdly_single_rsp", 512'(rcnt), 512'd0);

    // Response held off; a competing request must wait
    r_resp_i = 2'd0; r_id_i = 4'd0; r_last_i = 1'b1;
    set_rdata(64'h38, 64'h1234);
    issue(1'b0, 64'h38, 64'h0);
    wait_rsp(0);
    r_data_i = {8{64'hFFFF_0000_FFFF_0000}};
    req_we_i = 1'b1; req_addr_i = 64'h200; req_data_i = 64'hABCD; req_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_state", i), 512'({rsp_valid_o, req_ready_o, aw_valid_o}), 512'({1'b1, 1'b0, 1'b0}));
      chk($sformatf("hold%0d_data", i), 512'(rsp_data_o), 512'h1234);
    end
    req_valid_i = 1'b0;
    $display("[TB] txn hold addr=%h data=%h err=%0b", 64'h38, rsp_data_o, rsp_err_o);
    finish_rsp();

    // Reset while waiting on B, then a misaligned request
    b_valid_i = 1'b0;
    issue(1'b1, 64'h8, 64'h5A5A);
    rcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_ready_o) begin
        rcnt = 1;
        break;
      end
    end
    chk("rst_reached_wr_b", 512'(rcnt), 512'd1);
    rstn_i = 1'b0;
    #1;
    chk("midrst_valids", 512'({aw_valid_o, w_valid_o, ar_valid_o, rsp_valid_o, b_ready_o, r_ready_o}), 512'd0);
    chk("midrst_fields", 512'({aw_addr_o, w_strb_o, rsp_data_o, 1'(rsp_err_o)}), 512'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    b_valid_i = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 512'(req_ready_o), 512'd1);
    chk("midrst_idle", 512'({b_ready_o, rsp_valid_o}), 512'd0);
    issue(1'b0, 64'h4, 64'h0);
    wait_rsp(0);
    chk("mis_latency", 512'(lat), 512'd1);
    chk("mis_err", 512'(rsp_err_o), 512'd1);
    chk("mis_no_axi", 512'({saw_aw, saw_w, saw_ar, saw_bready}), 512'd0);
    $display("[TB] txn misaligned addr=%h err=%0b lat=%0d", 64'h4, rsp_err_o, lat);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_fromhost_master.md
Name: axi_fromhost_master

Overview:
- Simulation-side AXI4 initiator that delivers host-to-target traffic: fromhost writes and host polling reads of target memory. It is the counterpart of the tohost responder.
- Accepts one 64-bit request at a time on a valid/ready port and converts it into a single-beat AXI write (AW/W/B) or read (AR/R) on the DATA_W-wide bus.
- Returns completion data and an error flag on a response port.
- Sits between the DPI host model and the memory interconnect in the meep_shell simulator.

Parameters:
- ADDR_W, 64, AXI address width.
- DATA_W, 512, AXI data width; power of two, ≥64.
- ID_W, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on aw_id_o/ar_id_o.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  asynchronous active-low reset.
- req_valid_i / req_ready_o  in/out  1  request handshake.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  byte address; must be 8-byte aligned.
- req_data_i  in  64  write payload.
- rsp_valid_o / rsp_ready_i  out/in  1  response handshake.
- rsp_data_o  out  64  read data; 0 for writes.
- rsp_err_o  out  1  set when resp ≠ OKAY or the returned ID ≠ AXI_ID.
- aw_valid_o / aw_ready_i, aw_addr_o (ADDR_W), aw_id_o (ID_W)  AW channel.
- w_valid_o / w_ready_i, w_data_o (DATA_W), w_strb_o (DATA_W/8), w_last_o  W channel.
- b_valid_i / b_ready_o, b_resp_i (2), b_id_i (ID_W)  B channel.
- ar_valid_o / ar_ready_i, ar_addr_o (ADDR_W), ar_id_o (ID_W)  AR channel.
- r_valid_i / r_ready_o, r_data_i (DATA_W), r_resp_i (2), r_id_i (ID_W), r_last_i  R channel.
- ax_len_o  out  8  constant 0; drives both aw_len and ar_len.
- ax_size_o  out  3  constant 3 (8 bytes).
- ax_burst_o  out  2  constant INCR.

Behaviour:
- Reset values: all *_valid_o = 0; b_ready_o = r_ready_o = 0; addr/data/strb/rsp fields = 0; FSM = IDLE. After reset, req_ready_o = 1.
- Lane select: LANE = req_addr_i[log2(DATA_W/8)-1:3].
  - w_data_o = req_data_i replicated into every 64-bit lane.
  - w_strb_o = 0xFF shifted left by LANE*8; all other strobe bits 0.
  - Read data: rsp_data_o = r_data_i[LANE*64 +: 64].
- FSM states:
  - IDLE: req_ready_o = 1. On req handshake, register addr, data, we and LANE.
    - we = 1 → WR. The next cycle aw_valid_o = w_valid_o = 1, with w_last_o = 1.
    - we = 0 → RD_A with ar_valid_o = 1.
  - WR: AW and W are independent.
    - Each valid drops on its own handshake; aw_done and w_done flags record completion.
    - Both handshakes in the same cycle are legal.
    - Go to WR_B once both flags are set, or in the same cycle they both become set.
  - WR_B: b_ready_o = 1. On b_valid_i, capture err = (b_resp_i ≠ 0) | (b_id_i ≠ AXI_ID), rsp_data = 0 → RSP.
  - RD_A: ar_valid_o held until ar_ready_i → RD_R.
  - RD_R: r_ready_o = 1. On r_valid_i, capture the lane data and err = (r_resp_i ≠ 0) | (r_id_i ≠ AXI_ID) | ~r_last_i → RSP.
  - RSP: rsp_valid_o = 1, outputs stable until rsp_ready_i → IDLE, rsp_valid_o = 0.
- Handshake rules:
  - Valids are never withdrawn before the matching ready; payload stays stable while valid.
  - req_ready_o = 0 outside IDLE, so at most one outstanding transaction.
- Latency: with all AXI ready signals tied high and a same-cycle response, req handshake to rsp_valid_o is 3 cycles.
- Back-to-back: the cycle after the rsp handshake, IDLE accepts a new request.
- A response with no request outstanding (b_valid_i or r_valid_i outside WR_B/RD_R) is ignored; its ready stays 0.
- Reset asserted mid-transaction returns all outputs to their reset values immediately, and the in-flight transaction is abandoned.
- Misaligned address (req_addr_i[2:0] ≠ 0): no AXI traffic is issued; the block goes straight to RSP with rsp_err_o = 1.

Decomposition:
- fpga_pkg holds:
  - axi_resp_e (OKAY = 0, EXOKAY = 1, SLVERR = 2, DECERR = 3).
  - AXI_BURST_INCR constant.
  - the state enum fromhost_state_e {IDLE, WR, WR_B, RD_A, RD_R, RSP}.
- No sub-module; the lane/strobe computation is a local function.

Test Plan:
- Write addr 0x8000_1008, data 0xDEAD_BEEF_0000_0001, all readies high → aw_addr_o = 0x80001008, w_strb_o = 0xFF<<8, lane 1 = payload, rsp_valid_o 3 cycles after req, rsp_err_o = 0.
- AW ready delayed 5 cycles, W ready immediate → w_valid_o drops after 1 cycle, aw_valid_o holds 5 cycles, B accepted only after both; single rsp.
- Read addr 0x38 with r_data_i lane 7 = 0x1234 → rsp_data_o = 0x1234, rsp_err_o = 0.
- b_resp_i = SLVERR, then a read with r_id_i = 5 (AXI_ID = 0) → rsp_err_o = 1 for both.
- rsp_ready_i held low 10 cycles → rsp_valid_o and rsp_data_o stable, req_ready_o = 0; a req offered meanwhile is not accepted.
- rstn_i pulsed while in WR_B → all valid/ready outputs 0 immediately, req_ready_o = 1 after release; a misaligned addr 0x4 afterwards → rsp_err_o = 1 with no AXI valids.
